ipv4_vlg_rx: RTL and testbench

IPv4 receive parser between the MAC receive stage and the ICMP/UDP/TCP receivers. Consumes the MAC payload byte stream and the already-parsed MAC header, then extracts and validates the 20-byte IPv4 header. It delivers the IPv4 payload byte stream with an ipv4_meta_t descriptor and discards frames addressed elsewhere, malformed frames and fragmented frames.

---
 rtl/ipv4_vlg_pkg.sv | 52 +++++
 rtl/ipv4_vlg_rx_if.sv | 34 +++
 rtl/ipv4_vlg_cks.sv | 47 ++++
 rtl/ipv4_vlg_rx.sv | 176 +++++++++++++++++
 tb/tb_ipv4_vlg_rx.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ipv4_vlg_pkg.sv
// Shared IPv4 types and constants for the receive/transmit path.
// The header struct is laid out in wire order so a 160-bit shift register casts onto it directly.
package ipv4_vlg_pkg;

    typedef logic [31:0] ipv4_t;
    typedef logic [15:0] length_t;
    typedef logic [15:0] cks_t;
    typedef logic [47:0] mac_addr_t;

    typedef struct packed {
        mac_addr_t   dst_mac;
        mac_addr_t   src_mac;
        logic [15:0] ethertype;
    } mac_hdr_t;

    typedef struct packed {
        logic [3:0]  ver;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        length_t     length;
        logic [15:0] id;
        logic        rsv;
        logic        df;
        logic        mf;
        logic [12:0] fo;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        cks_t        cks;
        ipv4_t       src_ip;
        ipv4_t       dst_ip;
    } ipv4_hdr_t;

    typedef struct packed {
        ipv4_hdr_t ipv4_hdr;
        mac_hdr_t  mac_hdr;
        length_t   pld_len;
        logic      mac_known;
    } ipv4_meta_t;

    localparam ipv4_t      IPV4_BROADCAST = 32'hFFFF_FFFF;
    localparam logic [3:0] IPV4_VER       = 4'd4;
    localparam logic [3:0] IPV4_IHL_MIN   = 4'd5;
    localparam length_t    IPV4_HDR_LEN   = 16'd20;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_HDR,
        RX_PLD,
        RX_DROP
    } ipv4_rx_state_t;

endpackage

// File: rtl/ipv4_vlg_rx_if.sv
// Byte-stream bundle between the MAC receive stage, the IPv4 parser and its consumers.
interface ipv4_vlg_rx_if;
    import ipv4_vlg_pkg::*;

    // No backpressure: a byte transfers on every clock where *_val is high; sof/eof/err
    // are only meaningful while *_val is high (out_eof may also close a stream alone).
    logic [7:0]     in_dat;
    logic           in_val;
    logic           in_sof;
    logic           in_eof;
    logic           in_err;
    mac_hdr_t       mac_hdr;

    logic [7:0]     out_dat;
    logic           out_val;
    logic           out_sof;
    logic           out_eof;
    logic           out_err;
    ipv4_meta_t     meta;
    logic           meta_val;
    logic           drop;
    ipv4_rx_state_t dbg_state;

    modport master (
        output in_dat, in_val, in_sof, in_eof, in_err, mac_hdr,
        input  out_dat, out_val, out_sof, out_eof, out_err, meta, meta_val, drop, dbg_state
    );

    modport slave (
        input  in_dat, in_val, in_sof, in_eof, in_err, mac_hdr,
        output out_dat, out_val, out_sof, out_eof, out_err, meta, meta_val, drop, dbg_state
    );

endinterface

// File: rtl/ipv4_vlg_cks.sv
// Streaming ones'-complement 16-bit accumulator fed one byte at a time (high byte first).
// ok_o reports whether the sum, including the byte currently presented, folds to 16'hFFFF.
module ipv4_vlg_cks
    import ipv4_vlg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] dat_i,
    output logic       ok_o
);

    logic        phase_q;
    logic [7:0]  hi_q;
    cks_t        sum_q;
    cks_t        sum_d;
    cks_t        base;
    logic        phase;
    logic [16:0] add;

    // clr_i applies before the byte on the same cycle, so that byte opens a new stream.
    always_comb begin
        phase = clr_i ? 1'b0 : phase_q;
        base  = clr_i ? 16'h0000 : sum_q;
        add   = {1'b0, base} + {1'b0, hi_q, dat_i};
        sum_d = (en_i && phase) ? (add[15:0] + {15'd0, add[16]}) : base;
    end

    assign ok_o = (sum_d == 16'hFFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
            sum_q   <= 16'h0000;
        end else if (en_i) begin
            phase_q <= ~phase;
            if (!phase) hi_q <= dat_i;
            sum_q   <= sum_d;
        end else if (clr_i) begin
            phase_q <= 1'b0;
            sum_q   <= 16'h0000;
        end
    end

endmodule

// File: rtl/ipv4_vlg_rx.sv
// IPv4 receive parser: shifts in the 20-byte header, validates it, then forwards the payload
// with a descriptor. Foreign, malformed and fragmented packets are discarded.
module ipv4_vlg_rx
    import ipv4_vlg_pkg::*;
#(
    parameter bit CHECK_CKS    = 1'b1,
    parameter bit ACCEPT_BCAST = 1'b1
)(
    input  logic          clk,
    input  logic          rst_n,
    input  ipv4_t         dev_ip,
    ipv4_vlg_rx_if.slave  bus
);

    ipv4_rx_state_t state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [151:0]   hdr_q, hdr_d;
    mac_hdr_t       mac_q, mac_d;
    length_t        rem_q, rem_d;
    logic           first_q, first_d;
    logic [7:0]     out_dat_q, out_dat_d;
    logic           out_val_q, out_val_d, out_sof_q, out_sof_d;
    logic           out_eof_q, out_eof_d, out_err_q, out_err_d;
    logic           meta_val_q, meta_val_d, drop_q, drop_d;
    ipv4_meta_t     meta_q, meta_d;

    logic [159:0]   hdr_sh;
    ipv4_hdr_t      hdr_v;
    length_t        pld_len;
    logic           cks_clr, cks_en, cks_ok, dst_ok, accept;

    // The 20th byte completes the header combinationally, so the decision lands on its edge.
    assign hdr_sh  = {hdr_q, bus.in_dat};
    assign hdr_v   = ipv4_hdr_t'(hdr_sh);
    assign pld_len = hdr_v.length - IPV4_HDR_LEN;
    assign dst_ok  = (hdr_v.dst_ip == dev_ip) ||
                     (ACCEPT_BCAST && (hdr_v.dst_ip == IPV4_BROADCAST));
    assign accept  = (hdr_v.ver == IPV4_VER) && (hdr_v.ihl == IPV4_IHL_MIN) &&
                     !hdr_v.mf && (hdr_v.fo == 13'd0) && (hdr_v.length >= IPV4_HDR_LEN) &&
                     dst_ok && (cks_ok || !CHECK_CKS);

    ipv4_vlg_cks u_cks (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cks_clr),
        .en_i  (cks_en),
        .dat_i (bus.in_dat),
        .ok_o  (cks_ok)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        mac_d      = mac_q;
        rem_d      = rem_q;
        first_d    = first_q;
        meta_d     = meta_q;
        out_dat_d  = out_dat_q;
        out_val_d  = 1'b0;
        out_sof_d  = 1'b0;
        out_eof_d  = 1'b0;
        out_err_d  = 1'b0;
        meta_val_d = 1'b0;
        drop_d     = 1'b0;
        cks_clr    = 1'b0;
        cks_en     = 1'b0;
        if (bus.in_val) begin
            if (bus.in_sof) begin
                // Close an open payload stream before restarting on the new frame.
                if (state_q == RX_PLD && !first_q) begin
                    out_eof_d = 1'b1;
                    out_err_d = 1'b1;
                end
                state_d = RX_HDR;
                cnt_d   = 5'd1;
                hdr_d   = hdr_sh[151:0];
                mac_d   = bus.mac_hdr;
                cks_clr = 1'b1;
                cks_en  = 1'b1;
            end else begin
                case (state_q)
                    RX_HDR: begin
                        hdr_d  = hdr_sh[151:0];
                        cnt_d  = cnt_q + 5'd1;
                        cks_en = 1'b1;
                        if (cnt_q == 5'd19) begin
                            if (accept) begin
                                meta_d.ipv4_hdr  = hdr_v;
                                meta_d.mac_hdr   = mac_q;
                                meta_d.pld_len   = pld_len;
                                meta_d.mac_known = 1'b1;
                                rem_d            = pld_len;
                                first_d          = 1'b1;
                            end else begin
                                drop_d = 1'b1;
                            end
                            if (accept && pld_len != 16'd0 && !bus.in_eof) state_d = RX_PLD;
                            else if (bus.in_eof)                         state_d = RX_IDLE;
                            else                                         state_d = RX_DROP;
                            // Header accepted but frame already over: nothing was delivered.
                            if (accept && pld_len != 16'd0 && bus.in_eof) drop_d = 1'b1;
                        end else if (bus.in_eof) begin
                            drop_d  = 1'b1;
                            state_d = RX_IDLE;
                        end
                    end
                    RX_PLD: begin
                        out_val_d  = 1'b1;
                        out_dat_d  = bus.in_dat;
                        out_sof_d  = first_q;
                        meta_val_d = first_q;
                        first_d    = 1'b0;
                        rem_d      = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            out_eof_d = 1'b1;
                            out_err_d = bus.in_eof & bus.in_err;
                            state_d   = bus.in_eof ? RX_IDLE : RX_DROP;
                        end else if (bus.in_eof) begin
                            out_eof_d = 1'b1;
                            out_err_d = 1'b1;
                            state_d   = RX_IDLE;
                        end
                    end
                    RX_DROP: if (bus.in_eof) state_d = RX_IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RX_IDLE;
            cnt_q      <= 5'd0;
            hdr_q      <= '0;
            mac_q      <= '0;
            rem_q      <= 16'd0;
            first_q    <= 1'b0;
            meta_q     <= '0;
            out_dat_q  <= 8'h00;
            out_val_q  <= 1'b0;
            out_sof_q  <= 1'b0;
            out_eof_q  <= 1'b0;
            out_err_q  <= 1'b0;
            meta_val_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            mac_q      <= mac_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            meta_q     <= meta_d;
            out_dat_q  <= out_dat_d;
            out_val_q  <= out_val_d;
            out_sof_q  <= out_sof_d;
            out_eof_q  <= out_eof_d;
            out_err_q  <= out_err_d;
            meta_val_q <= meta_val_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.out_dat   = out_dat_q;
    assign bus.out_val   = out_val_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.out_err   = out_err_q;
    assign bus.meta      = meta_q;
    assign bus.meta_val  = meta_val_q;
    assign bus.drop      = drop_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ipv4_vlg_rx.sv
// Directed bench for ipv4_vlg_rx: two instances (default parameters, and checksum/broadcast
// disabled) see the same frames; expected output events are queued and popped by monitors.
module tb_ipv4_vlg_rx;
    import ipv4_vlg_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b1;
    ipv4_t dev_ip = 32'hC0A8_00C7;

    always #5 clk = ~clk;

    ipv4_vlg_rx_if bus_a ();
    ipv4_vlg_rx_if bus_b ();

    ipv4_vlg_rx #(.CHECK_CKS(1'b1), .ACCEPT_BCAST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .dev_ip(dev_ip), .bus(bus_a));
    ipv4_vlg_rx #(.CHECK_CKS(1'b0), .ACCEPT_BCAST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .dev_ip(dev_ip), .bus(bus_b));

    assign bus_b.in_dat  = bus_a.in_dat;
    assign bus_b.in_val  = bus_a.in_val;
    assign bus_b.in_sof  = bus_a.in_sof;
    assign bus_b.in_eof  = bus_a.in_eof;
    assign bus_b.in_err  = bus_a.in_err;
    assign bus_b.mac_hdr = bus_a.mac_hdr;

    // Event word: {drop, val, sof, meta_val, eof, err, dat}; meta word: {pld_len, proto, mac_known, src_mac[7:0]}
    logic [13:0] exp_a[$], exp_b[$];
    logic [32:0] mexp_a[$], mexp_b[$];
    logic [13:0] act_a, act_b;
    logic [7:0]  frm[0:255];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [13:0] mk(input bit dr, input bit v, input bit s, input bit mv,
                                       input bit e, input bit er, input logic [7:0] d);
        return {dr, v, s, mv, e, er, d};
    endfunction

    function automatic logic [7:0] pb(input int k);
        return 8'(k * 7 + 3);
    endfunction

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (rst_n && (bus_a.out_val || bus_a.out_eof || bus_a.meta_val || bus_a.drop)) begin
            act_a = {bus_a.drop, bus_a.out_val, bus_a.out_sof, bus_a.meta_val, bus_a.out_eof,
                     bus_a.out_err, bus_a.out_val ? bus_a.out_dat : 8'h00};
            if (exp_a.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL a_unexpected_event: got %0h expected none", act_a);
            end else chk("a_event", 64'(act_a), 64'(exp_a.pop_front()));
            if (bus_a.meta_val) begin
                if (mexp_a.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL a_unexpected_meta: got %0h expected none", bus_a.meta.pld_len);
                end else chk("a_meta", 64'({bus_a.meta.pld_len, bus_a.meta.ipv4_hdr.proto,
                             bus_a.meta.mac_known, bus_a.meta.mac_hdr.src_mac[7:0]}),
                             64'(mexp_a.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (bus_b.out_val || bus_b.out_eof || bus_b.meta_val || bus_b.drop)) begin
            act_b = {bus_b.drop, bus_b.out_val, bus_b.out_sof, bus_b.meta_val, bus_b.out_eof,
                     bus_b.out_err, bus_b.out_val ? bus_b.out_dat : 8'h00};
            if (exp_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b_unexpected_event: got %0h expected none", act_b);
            end else chk("b_event", 64'(act_b), 64'(exp_b.pop_front()));
            if (bus_b.meta_val) begin
                if (mexp_b.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b_unexpected_meta: got %0h expected none", bus_b.meta.pld_len);
                end else chk("b_meta", 64'({bus_b.meta.pld_len, bus_b.meta.ipv4_hdr.proto,
                             bus_b.meta.mac_known, bus_b.meta.mac_hdr.src_mac[7:0]}),
                             64'(mexp_b.pop_front()));
            end
        end
    end

    // ---------------- expectation helpers ----------------
    task automatic exp_pld(input bit to_a, input bit to_b, input int n, input bit with_eof,
                           input bit last_err, input logic [15:0] plen, input logic [7:0] src);
        logic [13:0] it;
        for (int k = 0; k < n; k++) begin
            it = mk(1'b0, 1'b1, k == 0, k == 0, with_eof && k == n - 1,
                    with_eof && k == n - 1 && last_err, pb(k));
            if (to_a) exp_a.push_back(it);
            if (to_b) exp_b.push_back(it);
        end
        if (to_a) mexp_a.push_back({plen, 8'd17, 1'b1, src});
        if (to_b) mexp_b.push_back({plen, 8'd17, 1'b1, src});
    endtask

    task automatic exp_ev(input bit to_a, input bit to_b, input logic [13:0] it);
        if (to_a) exp_a.push_back(it);
        if (to_b) exp_b.push_back(it);
    endtask

    // ---------------- drivers ----------------
    task automatic set_hdr(input logic [15:0] w0, input logic [15:0] len, input logic [15:0] ff,
                           input logic [15:0] ck, input ipv4_t dst);
        logic [159:0] h;
        h = {w0, len, 16'h0000, ff, 16'h4011, ck, 32'hC0A8_0001, dst};
        for (int i = 0; i < 20; i++) frm[i] = h[159 - 8*i -: 8];
    endtask

    task automatic fill_pld(input int n);
        for (int k = 0; k < n; k++) frm[20 + k] = pb(k);
    endtask

    task automatic drive(input logic [7:0] d, input bit s, input bit e, input bit er);
        bus_a.in_dat = d;
        bus_a.in_val = 1'b1;
        bus_a.in_sof = s;
        bus_a.in_eof = e;
        bus_a.in_err = er;
        @(posedge clk); #1;
        bus_a.in_val = 1'b0;
        bus_a.in_sof = 1'b0;
        bus_a.in_eof = 1'b0;
        bus_a.in_err = 1'b0;
    endtask

    task automatic send(input int first, input int last, input bit do_sof, input bit do_eof,
                        input bit er, input logic [7:0] src);
        if (do_sof) begin
            bus_a.mac_hdr.dst_mac   = 48'h0200_0000_00C7;
            bus_a.mac_hdr.src_mac   = {40'h02_0000_0000, src};
            bus_a.mac_hdr.ethertype = 16'h0800;
        end
        for (int i = first; i <= last; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            drive(frm[i], do_sof && i == first, do_eof && i == last, er && do_eof && i == last);
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus_a.in_dat = 8'h00; bus_a.in_val = 1'b0; bus_a.in_sof = 1'b0;
        bus_a.in_eof = 1'b0;  bus_a.in_err = 1'b0; bus_a.mac_hdr = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("a_reset_outputs", {bus_a.out_val, bus_a.out_sof, bus_a.out_eof, bus_a.out_err,
                                bus_a.meta_val, bus_a.drop}, 0);
        chk("a_reset_meta", bus_a.meta, 0);
        chk("a_reset_state", bus_a.dbg_state, RX_IDLE);
        chk("b_reset_outputs", {bus_b.out_val, bus_b.out_sof, bus_b.out_eof, bus_b.out_err,
                                bus_b.meta_val, bus_b.drop}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: valid unicast, 95 payload bytes
        set_hdr(16'h4500, 16'h0073, 16'h4000, 16'hB861, 32'hC0A8_00C7); fill_pld(95);
        exp_pld(1, 1, 95, 1, 0, 16'd95, 8'd1);
        send(0, 114, 1, 1, 0, 8'd1);

        // 2: bad checksum B862, only the CHECK_CKS=0 instance accepts
        set_hdr(16'h4500, 16'h0073, 16'h4000, 16'hB862, 32'hC0A8_00C7); fill_pld(95);
        exp_ev(1, 0, mk(1, 0, 0, 0, 0, 0, 8'h00));
        exp_pld(0, 1, 95, 1, 0, 16'd95, 8'd2);
        send(0, 114, 1, 1, 0, 8'd2);

        // 3: length 0x001C in a 46-byte padded frame
        set_hdr(16'h4500, 16'h001C, 16'h4000, 16'hB8B8, 32'hC0A8_00C7); fill_pld(26);
        exp_pld(1, 1, 8, 1, 0, 16'd8, 8'd3);
        send(0, 45, 1, 1, 0, 8'd3);

        // 4: truncated after 50 of 95 payload bytes
        set_hdr(16'h4500, 16'h0073, 16'h4000, 16'hB861, 32'hC0A8_00C7); fill_pld(50);
        exp_pld(1, 1, 50, 1, 1, 16'd95, 8'd4);
        send(0, 69, 1, 1, 0, 8'd4);

        // 5: foreign destination
        set_hdr(16'h4500, 16'h0073, 16'h4000, 16'hB927, 32'hC0A8_0001); fill_pld(20);
        exp_ev(1, 1, mk(1, 0, 0, 0, 0, 0, 8'h00));
        send(0, 39, 1, 1, 0, 8'd5);

        // 6: broadcast, exact-length frame with MAC error on the final byte
        set_hdr(16'h4500, 16'h001C, 16'h4000, 16'h7A28, 32'hFFFF_FFFF); fill_pld(8);
        exp_pld(1, 0, 8, 1, 1, 16'd8, 8'd6);
        exp_ev(0, 1, mk(1, 0, 0, 0, 0, 0, 8'h00));
        send(0, 27, 1, 1, 1, 8'd6);

        // 7-11: ihl=6, mf=1, fo=1, ver=6, length=16 all rejected with valid checksums
        set_hdr(16'h4600, 16'h0073, 16'h4000, 16'hB761, 32'hC0A8_00C7); fill_pld(20);
        exp_ev(1, 1, mk(1, 0, 0, 0, 0, 0, 8'h00)); send(0, 39, 1, 1, 0, 8'd7);
        set_hdr(16'h4500, 16'h0073, 16'h2000, 16'hD861, 32'hC0A8_00C7);
        exp_ev(1, 1, mk(1, 0, 0, 0, 0, 0, 8'h00)); send(0, 39, 1, 1, 0, 8'd8);
        set_hdr(16'h4500, 16'h0073, 16'h4001, 16'hB860, 32'hC0A8_00C7);
        exp_ev(1, 1, mk(1, 0, 0, 0, 0, 0, 8'h00)); send(0, 39, 1, 1, 0, 8'd9);
        set_hdr(16'h6500, 16'h0073, 16'h4000, 16'h9861, 32'hC0A8_00C7);
        exp_ev(1, 1, mk(1, 0, 0, 0, 0, 0, 8'h00)); send(0, 39, 1, 1, 0, 8'd10);
        set_hdr(16'h4500, 16'h0010, 16'h4000, 16'hB8C4, 32'hC0A8_00C7);
        exp_ev(1, 1, mk(1, 0, 0, 0, 0, 0, 8'h00)); send(0, 39, 1, 1, 0, 8'd11);

        // 12: length 20, accepted with empty payload: no events at all
        set_hdr(16'h4500, 16'h0014, 16'h4000, 16'hB8C0, 32'hC0A8_00C7); fill_pld(26);
        send(0, 45, 1, 1, 0, 8'd12);

        // 13: frame ends inside the header
        set_hdr(16'h4500, 16'h0073, 16'h4000, 16'hB861, 32'hC0A8_00C7);
        exp_ev(1, 1, mk(1, 0, 0, 0, 0, 0, 8'h00));
        send(0, 9, 1, 1, 0, 8'd13);

        // 14: new sof after 10 payload bytes terminates the open stream, then frame 3 again
        fill_pld(95);
        exp_pld(1, 1, 10, 0, 0, 16'd95, 8'd14);
        exp_ev(1, 1, mk(0, 0, 0, 0, 1, 1, 8'h00));
        exp_pld(1, 1, 8, 1, 0, 16'd8, 8'd15);
        send(0, 29, 1, 0, 0, 8'd14);
        set_hdr(16'h4500, 16'h001C, 16'h4000, 16'hB8B8, 32'hC0A8_00C7); fill_pld(26);
        send(0, 45, 1, 1, 0, 8'd15);

        // 15: reset mid-payload, leftover bytes ignored, next frame parses
        set_hdr(16'h4500, 16'h0073, 16'h4000, 16'hB861, 32'hC0A8_00C7); fill_pld(95);
        exp_pld(1, 1, 5, 0, 0, 16'd95, 8'd16);
        send(0, 24, 1, 0, 0, 8'd16);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("a_midreset_outputs", {bus_a.out_val, bus_a.out_sof, bus_a.out_eof, bus_a.out_err,
                                   bus_a.meta_val, bus_a.drop}, 0);
        chk("a_midreset_meta", bus_a.meta, 0);
        chk("a_midreset_state", bus_a.dbg_state, RX_IDLE);
        chk("b_midreset_state", bus_b.dbg_state, RX_IDLE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(25, 44, 0, 1, 0, 8'd16);
        set_hdr(16'h4500, 16'h001C, 16'h4000, 16'hB8B8, 32'hC0A8_00C7); fill_pld(26);
        exp_pld(1, 1, 8, 1, 0, 16'd8, 8'd17);
        send(0, 45, 1, 1, 0, 8'd17);

        repeat (30) @(posedge clk);
        chk("a_events_left", exp_a.size(), 0);
        chk("b_events_left", exp_b.size(), 0);
        chk("a_meta_left", mexp_a.size(), 0);
        chk("b_meta_left", mexp_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
